usb_pkt_framer: RTL and testbench
=================================

Name: usb_pkt_framer

Overview:
- Upstream neighbour of the FT232H transmit stage in the 60 MHz USB domain.
- Takes a 16-bit sample stream through a valid/ready handshake and frames it into byte packets.
- Writes the packet bytes into the show-ahead byte FIFO that the USB transmit stage drains.
- Packet format: A5, 5A, SEQ, LEN, payload (LEN samples, 2 bytes each, MSB first), CHK.

Parameters:
- SAMPLES_PER_PKT, 64: samples per packet. Legal range 1..255. Emitted as the LEN byte.
- SYNC0, 8'hA5: first sync byte.
- SYNC1, 8'h5A: second sync byte.

Ports:
- usb_clk_60m  in  1  FT232H 60 MHz clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- pkt_enable  in  1  permits the start of a new packet. Sampled only in IDLE.
- sample_valid  in  1  sample_data holds a valid sample.
- sample_data  in  16  sample value.
- sample_ready  out  1  framer accepts the sample this cycle.
- fifo_full  in  1  byte FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_din  out  8  FIFO write data.
- busy  out  1  high whenever state != IDLE.
- seq_num  out  8  SEQ value of the next (or current) packet.
- pkt_count  out  16  number of completed packets; wraps at 16'hFFFF.

Behaviour:
- Reset values (async, immediate): state=IDLE, fifo_wr_en=0, fifo_din=8'h00, sample_ready=0, busy=0, seq_num=0, pkt_count=0, checksum=0, lo-byte register=0.
- States: IDLE, S_SYNC0, S_SYNC1, S_SEQ, S_LEN, S_PAY_HI, S_PAY_LO, S_CHK.
- IDLE -> S_SYNC0 when pkt_enable && sample_valid. Clear checksum and sample counter.
- fifo_wr_en and fifo_din are combinational from registered state and registers, gated by fifo_full:
  - wr_en = (state in SYNC0/SYNC1/SEQ/LEN/PAY_LO/CHK) && !fifo_full.
  - In PAY_HI: wr_en = sample_valid && !fifo_full.
  - fifo_din = 8'h00 whenever wr_en = 0.
- A state advances only on a cycle where wr_en=1; otherwise it holds. This is the only stall mechanism and no byte is ever lost.
- Per-state bytes and actions:
  - S_SYNC0 writes SYNC0.
  - S_SYNC1 writes SYNC1.
  - S_SEQ writes seq_num.
  - S_LEN writes SAMPLES_PER_PKT[7:0].
  - S_PAY_HI: sample_ready = !fifo_full. On handshake, write sample_data[15:8], latch sample_data[7:0], go to S_PAY_LO.
  - S_PAY_LO writes the latched low byte. Increment the sample counter. Go to S_CHK if counter reaches SAMPLES_PER_PKT, else S_PAY_HI.
  - S_CHK writes the checksum byte, then seq_num+1 (8-bit wrap FF->00), pkt_count+1, go to IDLE.
- sample_ready is 0 in every state except S_PAY_HI.
- Checksum: XOR of the SEQ, LEN and all payload bytes, updated on each written byte. SYNC bytes are excluded.
- Latency: first byte (A5) is presented the cycle after the start condition is seen in IDLE. Minimum packet length is 5+2*SAMPLES_PER_PKT cycles.
- Packet start needs one IDLE cycle, so there is a 1-cycle gap between packets.
- pkt_enable deasserted mid-packet: ignored. The packet completes, then the framer stays in IDLE.
- sample_valid low mid-packet: framer waits in S_PAY_HI. There is no timeout.
- fifo_full and sample_valid both high in S_PAY_HI: no handshake and no write.
- Reset mid-packet: packet abandoned; seq_num restarts at 0. Downstream resynchronises on A5 5A.

Optional Feature:
- Macro: USB_PKT_CRC8_EN.
- Defined: CHK byte is CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, computed over the same bytes (SEQ, LEN, payload). Computed bytewise in a single cycle.
- Undefined: CHK is the plain XOR described above.
- Framing, timing and ports are identical in both builds.

Decomposition:
- Package usb_pkt_pkg holds:
  - state encoding (3-bit localparams for the 8 states);
  - default sync constants;
  - CRC8_POLY=8'h07;
  - HDR_BYTES=4 and TRL_BYTES=1.
- One sub-module, usb_pkt_chk8 (clear, en, din[7:0] -> chk[7:0]). It holds the XOR/CRC-8 accumulator and contains the USB_PKT_CRC8_EN selection.

Test Plan:
- Basic packet: SAMPLES_PER_PKT=2, samples 16'h1234 then 16'hABCD, fifo_full=0 -> FIFO receives A5 5A 00 02 12 34 AB CD 42. pkt_count=1, seq_num=1, busy low after CHK.
- Backpressure: same stimulus with fifo_full held high for 3 cycles at S_LEN and again during S_PAY_HI -> no writes and sample_ready=0 while full. Byte sequence identical to the basic case.
- Starved source: sample_valid low for 5 cycles between the two samples -> framer holds in S_PAY_HI with wr_en=0, then completes with the correct bytes.
- Sequence wrap: 257 back-to-back packets -> SEQ bytes run 00..FF,00. pkt_count=257. Exactly one IDLE cycle between packets.
- Enable drop and reset: pkt_enable low after the SEQ byte -> packet completes and no new packet starts. rst pulsed during S_PAY_LO -> all outputs return to reset values immediately, and the next packet starts with A5 5A 00.
- CRC build (USB_PKT_CRC8_EN defined): basic stimulus -> CHK equals the bench CRC-8 (poly 07, init 00) over 00 02 12 34 AB CD. All other bytes unchanged.

Source files
------------

// File: rtl/usb_pkt_pkg.sv
// Shared constants for the USB sample packet framer: state encoding, sync bytes,
// CRC-8 polynomial, and a bytewise CRC-8 helper.
package usb_pkt_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC0  = 3'd1;
  localparam logic [2:0] ST_SYNC1  = 3'd2;
  localparam logic [2:0] ST_SEQ    = 3'd3;
  localparam logic [2:0] ST_LEN    = 3'd4;
  localparam logic [2:0] ST_PAY_HI = 3'd5;
  localparam logic [2:0] ST_PAY_LO = 3'd6;
  localparam logic [2:0] ST_CHK    = 3'd7;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam int HDR_BYTES = 4;
  localparam int TRL_BYTES = 1;

  // One full byte of MSB-first CRC-8 (init and final XOR handled by the caller).
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    c = crc ^ din;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_pkt_chk8.sv
// Packet check-byte accumulator: plain XOR by default, CRC-8 (poly 0x07, init 0)
// when USB_PKT_CRC8_EN is defined.
module usb_pkt_chk8
  import usb_pkt_pkg::*;
(
  input  logic       usb_clk_60m,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] chk
);

  logic [7:0] acc_reg;
  logic [7:0] acc_next;

`ifdef USB_PKT_CRC8_EN
  assign acc_next = crc8_byte(acc_reg, din);
`else
  assign acc_next = acc_reg ^ din;
`endif

  always_ff @(posedge usb_clk_60m or posedge rst) begin
    if (rst) begin
      acc_reg <= 8'h00;
    end else if (clear) begin
      acc_reg <= 8'h00;
    end else if (en) begin
      acc_reg <= acc_next;
    end
  end

  assign chk = acc_reg;

endmodule

// File: rtl/usb_pkt_framer.sv
// Frames a 16-bit sample stream into A5 5A SEQ LEN payload CHK byte packets for the
// FT232H transmit FIFO. Define USB_PKT_CRC8_EN to make CHK a CRC-8 instead of XOR.
module usb_pkt_framer
  import usb_pkt_pkg::*;
#(
  parameter int         SAMPLES_PER_PKT = 64,
  parameter logic [7:0] SYNC0           = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1           = SYNC1_DEFAULT
) (
  input  logic        usb_clk_60m,
  input  logic        rst,
  input  logic        pkt_enable,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        sample_ready,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_din,
  output logic        busy,
  output logic [7:0]  seq_num,
  output logic [15:0] pkt_count
);

  localparam logic [7:0] LEN_BYTE = 8'(SAMPLES_PER_PKT);

  logic [2:0]  state_reg;
  logic [7:0]  seq_reg;
  logic [15:0] count_reg;
  logic [7:0]  lo_reg;
  logic [7:0]  smp_cnt_reg;

  logic        wr_en;
  logic        ready;
  logic [7:0]  byte_sel;
  logic        start;
  logic        chk_en;
  logic [7:0]  chk;
  logic        last_sample;

  // Every write is gated by fifo_full, so a full FIFO simply freezes the state.
  always_comb begin
    wr_en    = 1'b0;
    ready    = 1'b0;
    byte_sel = 8'h00;
    case (state_reg)
      ST_SYNC0:  begin wr_en = !fifo_full; byte_sel = SYNC0;     end
      ST_SYNC1:  begin wr_en = !fifo_full; byte_sel = SYNC1;     end
      ST_SEQ:    begin wr_en = !fifo_full; byte_sel = seq_reg;   end
      ST_LEN:    begin wr_en = !fifo_full; byte_sel = LEN_BYTE;  end
      ST_PAY_HI: begin
        ready    = !fifo_full;
        wr_en    = sample_valid && !fifo_full;
        byte_sel = sample_data[15:8];
      end
      ST_PAY_LO: begin wr_en = !fifo_full; byte_sel = lo_reg;    end
      ST_CHK:    begin wr_en = !fifo_full; byte_sel = chk;       end
      default:   ;
    endcase
  end

  assign fifo_wr_en   = wr_en;
  assign fifo_din     = wr_en ? byte_sel : 8'h00;
  assign sample_ready = ready;
  assign busy         = (state_reg != ST_IDLE);
  assign seq_num      = seq_reg;
  assign pkt_count    = count_reg;

  assign start       = (state_reg == ST_IDLE) && pkt_enable && sample_valid;
  assign last_sample = ((smp_cnt_reg + 8'd1) == LEN_BYTE);
  // SYNC bytes and the check byte itself stay out of the accumulator.
  assign chk_en      = wr_en && ((state_reg == ST_SEQ) || (state_reg == ST_LEN) ||
                                 (state_reg == ST_PAY_HI) || (state_reg == ST_PAY_LO));

  usb_pkt_chk8 u_chk (
    .usb_clk_60m (usb_clk_60m),
    .rst         (rst),
    .clear       (start),
    .en          (chk_en),
    .din         (byte_sel),
    .chk         (chk)
  );

  always_ff @(posedge usb_clk_60m or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      seq_reg     <= 8'h00;
      count_reg   <= 16'h0000;
      lo_reg      <= 8'h00;
      smp_cnt_reg <= 8'h00;
    end else if (start) begin
      state_reg   <= ST_SYNC0;
      smp_cnt_reg <= 8'h00;
    end else if (wr_en) begin
      case (state_reg)
        ST_SYNC0:  state_reg <= ST_SYNC1;
        ST_SYNC1:  state_reg <= ST_SEQ;
        ST_SEQ:    state_reg <= ST_LEN;
        ST_LEN:    state_reg <= ST_PAY_HI;
        ST_PAY_HI: begin
          lo_reg    <= sample_data[7:0];
          state_reg <= ST_PAY_LO;
        end
        ST_PAY_LO: begin
          smp_cnt_reg <= smp_cnt_reg + 8'd1;
          state_reg   <= last_sample ? ST_CHK : ST_PAY_HI;
        end
        ST_CHK: begin
          seq_reg   <= seq_reg + 8'd1;
          count_reg <= count_reg + 16'd1;
          state_reg <= ST_IDLE;
        end
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_pkt_framer.sv
// Randomized self-checking bench for usb_pkt_framer (SAMPLES_PER_PKT=2); the expected
// byte stream is built from the packet format rules. Honors USB_PKT_CRC8_EN.
module tb_usb_pkt_framer;

  localparam int SPP = 2;

  logic        usb_clk_60m = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = 16'h0000;
  logic        fifo_full = 1'b0;
  logic        sample_ready;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        busy;
  logic [7:0]  seq_num;
  logic [15:0] pkt_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  m_seq = 8'h00;
  logic [15:0] m_cnt = 16'h0000;
  logic [15:0] stream_s [2*257];

  usb_pkt_framer #(.SAMPLES_PER_PKT(SPP)) dut (
    .usb_clk_60m  (usb_clk_60m),
    .rst          (rst),
    .pkt_enable   (pkt_enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .busy         (busy),
    .seq_num      (seq_num),
    .pkt_count    (pkt_count)
  );

  always #8 usb_clk_60m = ~usb_clk_60m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  // Reference check byte: XOR of body bytes, or bit-serial CRC-8 poly 07 init 00.
  function automatic logic [7:0] ref_chk(input logic [7:0] body[$]);
    logic [7:0] acc;
    acc = 8'h00;
    foreach (body[k]) begin
`ifdef USB_PKT_CRC8_EN
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb  = acc[7] ^ body[k][b];
        acc = {acc[6:0], 1'b0};
        if (fb) acc = acc ^ 8'h07;
      end
`else
      acc = acc ^ body[k];
`endif
    end
    return acc;
  endfunction

  function automatic void push_packet(input logic [7:0] seq, input logic [15:0] s0,
                                      input logic [15:0] s1);
    logic [7:0] body[$];
    body = '{seq, 8'(SPP), s0[15:8], s0[7:0], s1[15:8], s1[7:0]};
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    foreach (body[k]) exp_q.push_back(body[k]);
    exp_q.push_back(ref_chk(body));
  endfunction

  always @(negedge usb_clk_60m) begin
    if (!rst) begin
      if (fifo_wr_en) got_q.push_back(fifo_din);
      else check("din_idle", fifo_din, 8'h00);
      if (fifo_full) begin
        check("wr_while_full", fifo_wr_en, 1'b0);
        check("ready_while_full", sample_ready, 1'b0);
      end
    end
  end

  task automatic compare_stream();
    while (exp_q.size() > 0) begin
      if (got_q.size() == 0) begin
        check("byte_missing", exp_q.size(), 0);
        exp_q.delete();
      end else begin
        check("byte", got_q.pop_front(), exp_q.pop_front());
      end
    end
    check("byte_extra", got_q.size(), 0);
    got_q.delete();
  endtask

  task automatic send_packet(input logic [15:0] s0, input logic [15:0] s1,
                             input int full_pct, input int starve_pct, input bit drop_en);
    logic [15:0] smp [SPP];
    int idx;
    int cyc;
    int base;
    bit hs;
    smp[0] = s0;
    smp[1] = s1;
    push_packet(m_seq, s0, s1);
    idx  = 0;
    cyc  = 0;
    base = got_q.size();
    pkt_enable   = 1'b1;
    sample_data  = s0;
    sample_valid = !pct(starve_pct);
    fifo_full    = pct(full_pct);
    forever begin
      @(negedge usb_clk_60m);
      if (idx == SPP && !busy) break;
      if (cyc >= 3000) begin
        check("pkt_timeout", cyc, 0);
        break;
      end
      hs = sample_valid && sample_ready;
      @(posedge usb_clk_60m);
      #1;
      cyc++;
      if (hs) idx++;
      if (drop_en && got_q.size() >= base + 3) pkt_enable = 1'b0;
      if (idx < SPP) begin
        sample_data  = smp[idx];
        sample_valid = !pct(starve_pct);
      end else begin
        pkt_enable   = 1'b0;
        sample_valid = drop_en;
        sample_data  = 16'($urandom);
      end
      fifo_full = pct(full_pct);
    end
    fifo_full = 1'b0;
    m_seq = m_seq + 8'd1;
    m_cnt = m_cnt + 16'd1;
    check("seq_num", seq_num, m_seq);
    check("pkt_count", pkt_count, m_cnt);
    if (drop_en) begin
      repeat (6) begin
        @(negedge usb_clk_60m);
        check("no_restart", busy, 1'b0);
      end
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    bit hs;
    int hs_cnt;
    int idle_run;
    int cyc;
    bit seen_busy;
    bit prev_busy;

    repeat (3) @(posedge usb_clk_60m);
    #1;
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_din", fifo_din, 8'h00);
    check("rst_ready", sample_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_seq", seq_num, 8'h00);
    check("rst_count", pkt_count, 16'h0000);
    rst = 1'b0;

    send_packet(16'h1234, 16'hABCD, 0, 0, 1'b0);
    compare_stream();
    send_packet(16'h1234, 16'hABCD, 50, 0, 1'b0);
    compare_stream();
    send_packet(16'h1234, 16'hABCD, 0, 60, 1'b0);
    compare_stream();
    for (int i = 0; i < 20; i++) begin
      send_packet(16'($urandom), 16'($urandom), $urandom_range(60), $urandom_range(60), 1'b0);
    end
    compare_stream();
    send_packet(16'($urandom), 16'($urandom), 20, 20, 1'b1);
    compare_stream();

    // Reset while the low byte of the first sample is pending.
    begin
      logic [15:0] s0;
      s0 = 16'($urandom);
      pkt_enable   = 1'b1;
      sample_valid = 1'b1;
      sample_data  = s0;
      fifo_full    = 1'b0;
      hs = 1'b0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge usb_clk_60m);
        hs = sample_valid && sample_ready;
      end
      check("rst_hs_seen", hs, 1'b1);
      @(posedge usb_clk_60m);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_wr_en", fifo_wr_en, 1'b0);
      check("mid_rst_din", fifo_din, 8'h00);
      check("mid_rst_ready", sample_ready, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_seq", seq_num, 8'h00);
      check("mid_rst_count", pkt_count, 16'h0000);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(m_seq);
      exp_q.push_back(8'(SPP));
      exp_q.push_back(s0[15:8]);
      m_seq = 8'h00;
      m_cnt = 16'h0000;
      sample_valid = 1'b0;
      pkt_enable   = 1'b0;
      @(posedge usb_clk_60m);
      #1;
      rst = 1'b0;
    end
    send_packet(16'($urandom), 16'($urandom), 0, 0, 1'b0);
    compare_stream();

    rst = 1'b1;
    #1;
    check("pulse_rst_count", pkt_count, 16'h0000);
    @(posedge usb_clk_60m);
    #1;
    rst = 1'b0;
    m_seq = 8'h00;
    m_cnt = 16'h0000;

    // 257 back-to-back packets: SEQ wraps FF->00, exactly one idle cycle between packets.
    for (int p = 0; p < 257; p++) begin
      stream_s[2*p]   = 16'($urandom);
      stream_s[2*p+1] = 16'($urandom);
      push_packet(m_seq, stream_s[2*p], stream_s[2*p+1]);
      m_seq = m_seq + 8'd1;
      m_cnt = m_cnt + 16'd1;
    end
    hs_cnt = 0;
    idle_run = 0;
    cyc = 0;
    seen_busy = 1'b0;
    prev_busy = 1'b0;
    pkt_enable   = 1'b1;
    sample_valid = 1'b1;
    sample_data  = stream_s[0];
    while (hs_cnt < 2*257 && cyc < 6000) begin
      @(negedge usb_clk_60m);
      if (busy) begin
        if (!prev_busy && seen_busy) check("idle_gap", idle_run, 1);
        idle_run  = 0;
        seen_busy = 1'b1;
      end else begin
        idle_run++;
      end
      prev_busy = busy;
      hs = sample_valid && sample_ready;
      @(posedge usb_clk_60m);
      #1;
      cyc++;
      if (hs) hs_cnt++;
      if (hs_cnt < 2*257) begin
        sample_data = stream_s[hs_cnt];
      end else begin
        sample_valid = 1'b0;
        pkt_enable   = 1'b0;
      end
    end
    check("stream_samples", hs_cnt, 2*257);
    cyc = 0;
    do begin
      @(negedge usb_clk_60m);
      cyc++;
    end while (busy && cyc < 50);
    check("stream_end_idle", busy, 1'b0);
    check("stream_seq", seq_num, m_seq);
    check("stream_count", pkt_count, m_cnt);
    compare_stream();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
